// File: rtl/mem_bridge_pkg.sv
// Shared types and constants for the mem_bridge memory-side stage.
// The optional timeout watchdog is enabled with MEM_BRIDGE_TIMEOUT_EN.
package mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2,
    DONE      = 2'd3
  } state_e;

  localparam int XLEN_DEF   = 32;
  localparam int ADDR_W_DEF = 32;

  localparam logic [31:0] TIMEOUT_DATA = 32'h0;

endpackage

// File: rtl/mem_bridge_if.sv
// Valid/ready request plus response-valid bus toward memory.
// master = bridge side, slave = memory side.
interface mem_bridge_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
);

  logic              valid;
  logic              ready;
  logic              we;
  logic [ADDR_W-1:0] adr;
  logic [XLEN-1:0]   wdata;
  logic              rvalid;
  logic [XLEN-1:0]   rdata;

  modport master (
    output valid, we, adr, wdata,
    input  ready, rvalid, rdata
  );

  modport slave (
    input  valid, we, adr, wdata,
    output ready, rvalid, rdata
  );

endinterface

// File: rtl/mem_bridge_watchdog.sv
// Cycle watchdog for the bridge: counts REQ/WAIT_RESP cycles.
// Only built when MEM_BRIDGE_TIMEOUT_EN is defined.
`ifdef MEM_BRIDGE_TIMEOUT_EN
module bridge_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic start_i,
  input  logic run_i,
  output logic expire_o
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i)
      cnt_d = '0;
    else if (run_i)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  // Fires in the TIMEOUT-th busy cycle so the FSM lands in DONE next.
  assign expire_o = run_i && (cnt_q == CW'(TIMEOUT - 1));

endmodule
`endif

// File: rtl/mem_bridge.sv
// Core-to-memory bridge: latches one access, runs valid/ready + rvalid.
// MEM_BRIDGE_TIMEOUT_EN adds a watchdog abort with sticky bus_err.
module mem_bridge
  import mem_bridge_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_adr,
  input  logic [XLEN-1:0]   core_wdata,
  output logic [XLEN-1:0]   core_rdata,
  output logic              core_stall,
  mem_bridge_if.master      mem,
  output logic              bus_err
);

  state_e            state_q;
  logic              valid_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [XLEN-1:0]   rdata_q;
  logic              err_q;
  logic              expire;
  logic              busy;

  assign busy = (state_q == REQ) || (state_q == WAIT_RESP);

`ifdef MEM_BRIDGE_TIMEOUT_EN
  bridge_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (clk),
    .reset    (reset),
    .start_i  ((state_q == IDLE) && core_req),
    .run_i    (busy),
    .expire_o (expire)
  );
`else
  assign expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (core_req) begin
            state_q <= REQ;
            valid_q <= 1'b1;
            we_q    <= core_we;
            adr_q   <= core_adr;
            wdata_q <= core_wdata;
          end
        end
        REQ: begin
          if (mem.ready) begin
            valid_q <= 1'b0;
            state_q <= we_q ? DONE : WAIT_RESP;
          end else if (expire) begin
            valid_q <= 1'b0;
            state_q <= DONE;
            err_q   <= 1'b1;
            if (!we_q)
              rdata_q <= XLEN'(TIMEOUT_DATA);
          end
        end
        WAIT_RESP: begin
          if (mem.rvalid) begin
            rdata_q <= mem.rdata;
            state_q <= DONE;
          end else if (expire) begin
            state_q <= DONE;
            err_q   <= 1'b1;
            rdata_q <= XLEN'(TIMEOUT_DATA);
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Stall follows the request while reset is held, whatever the state.
  assign core_stall = core_req && (reset || (state_q != DONE));
  assign core_rdata = rdata_q;
  assign bus_err    = err_q;
  assign mem.valid  = valid_q;
  assign mem.we     = we_q;
  assign mem.adr    = adr_q;
  assign mem.wdata  = wdata_q;

endmodule
